// File: rtl/x1_hazard_ctl_pkg.sv
// Shared constants and types for the X1 hazard controller.
package x1_hazard_ctl_pkg;

    localparam int unsigned DATA_W              = 32;
    localparam int unsigned REG_W               = 5;
    localparam int unsigned DIV_CNT_W           = 6;
    localparam int unsigned DIV_LATENCY_DEFAULT = 32;

    // Architectural zero register: never a forwarding target.
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Writeback tuple presented by one downstream stage.
    typedef struct packed {
        logic              reg_write;
        logic [REG_W-1:0]  rd;
        logic              ready;
        logic [DATA_W-1:0] result;
    } stage_t;

    // Source chosen for one forwarded operand.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W1 = 2'd1,
        FWD_M1 = 2'd2,
        FWD_X2 = 2'd3
    } fwd_src_e;

    // A stage supplies an operand when it writes a nonzero source register.
    function automatic logic stage_hit(input stage_t s, input logic [REG_W-1:0] src);
        return s.reg_write && (s.rd == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/x1_hazard_ctl_fwd_select.sv
// Per-operand bypass selection and read-after-write hazard detection.
module x1_hazard_ctl_fwd_select
    import x1_hazard_ctl_pkg::*;
(
    input  logic [REG_W-1:0]  i_src,
    input  logic              i_need,
    input  stage_t            i_x2,
    input  stage_t            i_m1,
    input  stage_t            i_w1,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic [DATA_W-1:0] o_fwd_data_c,
    output logic              o_hazard_c
);

    fwd_src_e w_sel;

    // Youngest matching stage wins: X2, then M1, then W1, else register file.
    always_comb begin
        w_sel = FWD_RF;
        if (stage_hit(i_x2, i_src)) begin
            w_sel = FWD_X2;
        end else if (stage_hit(i_m1, i_src)) begin
            w_sel = FWD_M1;
        end else if (stage_hit(i_w1, i_src)) begin
            w_sel = FWD_W1;
        end
    end

    // Data mux plus hazard when the chosen producer has no result yet.
    always_comb begin
        o_fwd_data_c = i_rf_data;
        o_hazard_c   = 1'b0;
        case (w_sel)
            FWD_X2: begin
                o_fwd_data_c = i_x2.result;
                o_hazard_c   = i_need & ~i_x2.ready;
            end
            FWD_M1: begin
                o_fwd_data_c = i_m1.result;
                o_hazard_c   = i_need & ~i_m1.ready;
            end
            FWD_W1: begin
                o_fwd_data_c = i_w1.result;
                o_hazard_c   = i_need & ~i_w1.ready;
            end
            default: begin
                o_fwd_data_c = i_rf_data;
                o_hazard_c   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/x1_hazard_ctl.sv
// X1 stage stall/flush/issue control, operand forwarding, divide interlock
// and saturating stall-cycle counter.
module x1_hazard_ctl
    import x1_hazard_ctl_pkg::*;
#(
    parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   X1_Issued,
    input  logic [REG_W-1:0]       X1_Rs,
    input  logic [REG_W-1:0]       X1_Rt,
    input  logic                   X1_NeedRs,
    input  logic                   X1_NeedRt,
    input  logic [DATA_W-1:0]      X1_ReadData1,
    input  logic [DATA_W-1:0]      X1_ReadData2,
    input  logic                   X1_HiRead,
    input  logic                   X1_LoRead,
    input  logic                   X1_DivStart,
    input  logic                   X2_RegWrite,
    input  logic                   M1_RegWrite,
    input  logic                   W1_RegWrite,
    input  logic [REG_W-1:0]       X2_Rd,
    input  logic [REG_W-1:0]       M1_Rd,
    input  logic [REG_W-1:0]       W1_Rd,
    input  logic                   X2_Ready,
    input  logic                   M1_Ready,
    input  logic [DATA_W-1:0]      X2_Result,
    input  logic [DATA_W-1:0]      M1_Result,
    input  logic [DATA_W-1:0]      W1_Result,
    input  logic                   M1_Stall,
    input  logic                   W1_Exception,
    output logic                   X1_Stall,
    output logic                   X1_Flush,
    output logic                   X1_Issue,
    output logic [DATA_W-1:0]      X1_ReadData1_Fwd,
    output logic [DATA_W-1:0]      X1_ReadData2_Fwd,
    output logic                   X1_DivBusy,
    output logic [STALL_CNT_W-1:0] X1_StallCount
);

    stage_t                 w_x2;
    stage_t                 w_m1;
    stage_t                 w_w1;
    logic                   w_haz_rs;
    logic                   w_haz_rt;
    logic                   w_div_busy;
    logic                   w_div_haz;
    logic                   w_stall;
    logic                   w_flush;
    logic                   w_issue;
    logic [DIV_CNT_W-1:0]   r_div_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    // Bundle the stage tuples; W1 results are always valid.
    assign w_x2 = {X2_RegWrite, X2_Rd, X2_Ready, X2_Result};
    assign w_m1 = {M1_RegWrite, M1_Rd, M1_Ready, M1_Result};
    assign w_w1 = {W1_RegWrite, W1_Rd, 1'b1,     W1_Result};

    x1_hazard_ctl_fwd_select u_fwd_rs (
        .i_src        (X1_Rs),
        .i_need       (X1_NeedRs),
        .i_x2         (w_x2),
        .i_m1         (w_m1),
        .i_w1         (w_w1),
        .i_rf_data    (X1_ReadData1),
        .o_fwd_data_c (X1_ReadData1_Fwd),
        .o_hazard_c   (w_haz_rs)
    );

    x1_hazard_ctl_fwd_select u_fwd_rt (
        .i_src        (X1_Rt),
        .i_need       (X1_NeedRt),
        .i_x2         (w_x2),
        .i_m1         (w_m1),
        .i_w1         (w_w1),
        .i_rf_data    (X1_ReadData2),
        .o_fwd_data_c (X1_ReadData2_Fwd),
        .o_hazard_c   (w_haz_rt)
    );

    // HI/LO access or a new divide must wait for the divider to drain.
    assign w_div_busy = (r_div_cnt != '0);
    assign w_div_haz  = X1_Issued & w_div_busy & (X1_HiRead | X1_LoRead | X1_DivStart);

    // Flush overrides every stall source; downstream stall holds X1 even when empty.
    always_comb begin
        w_flush = W1_Exception;
        w_stall = ~reset & ~W1_Exception &
                  ((X1_Issued & (w_haz_rs | w_haz_rt | w_div_haz)) | M1_Stall);
        w_issue = X1_Issued & ~w_stall & ~w_flush;
    end

    assign X1_Stall      = w_stall;
    assign X1_Flush      = w_flush;
    assign X1_Issue      = w_issue;
    assign X1_DivBusy    = w_div_busy;
    assign X1_StallCount = r_stall_cnt;

    // Divider occupancy: load on an issued divide, otherwise count down; flush does not cancel it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (X1_DivStart && w_issue) begin
            r_div_cnt <= DIV_CNT_W'(DIV_LATENCY);
        end else if (w_div_busy) begin
            r_div_cnt <= r_div_cnt - DIV_CNT_W'(1);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_x1_hazard_ctl.sv
// Directed scoreboard bench for x1_hazard_ctl (DIV_LATENCY=4, STALL_CNT_W=4).
module tb_x1_hazard_ctl;

    localparam logic [31:0] RD1 = 32'h1000_0001;
    localparam logic [31:0] RD2 = 32'h2000_0002;

    logic        clock = 1'b0;
    logic        reset;
    logic        X1_Issued;
    logic [4:0]  X1_Rs, X1_Rt;
    logic        X1_NeedRs, X1_NeedRt;
    logic [31:0] X1_ReadData1, X1_ReadData2;
    logic        X1_HiRead, X1_LoRead, X1_DivStart;
    logic        X2_RegWrite, M1_RegWrite, W1_RegWrite;
    logic [4:0]  X2_Rd, M1_Rd, W1_Rd;
    logic        X2_Ready, M1_Ready;
    logic [31:0] X2_Result, M1_Result, W1_Result;
    logic        M1_Stall, W1_Exception;
    logic        X1_Stall, X1_Flush, X1_Issue;
    logic [31:0] X1_ReadData1_Fwd, X1_ReadData2_Fwd;
    logic        X1_DivBusy;
    logic [3:0]  X1_StallCount;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        issue;
        logic [31:0] f1;
        logic [31:0] f2;
        logic        busy;
        logic [3:0]  cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clock = ~clock;

    x1_hazard_ctl #(.DIV_LATENCY(4), .STALL_CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .X1_Issued(X1_Issued), .X1_Rs(X1_Rs), .X1_Rt(X1_Rt),
        .X1_NeedRs(X1_NeedRs), .X1_NeedRt(X1_NeedRt),
        .X1_ReadData1(X1_ReadData1), .X1_ReadData2(X1_ReadData2),
        .X1_HiRead(X1_HiRead), .X1_LoRead(X1_LoRead), .X1_DivStart(X1_DivStart),
        .X2_RegWrite(X2_RegWrite), .M1_RegWrite(M1_RegWrite), .W1_RegWrite(W1_RegWrite),
        .X2_Rd(X2_Rd), .M1_Rd(M1_Rd), .W1_Rd(W1_Rd),
        .X2_Ready(X2_Ready), .M1_Ready(M1_Ready),
        .X2_Result(X2_Result), .M1_Result(M1_Result), .W1_Result(W1_Result),
        .M1_Stall(M1_Stall), .W1_Exception(W1_Exception),
        .X1_Stall(X1_Stall), .X1_Flush(X1_Flush), .X1_Issue(X1_Issue),
        .X1_ReadData1_Fwd(X1_ReadData1_Fwd), .X1_ReadData2_Fwd(X1_ReadData2_Fwd),
        .X1_DivBusy(X1_DivBusy), .X1_StallCount(X1_StallCount)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    endtask

    // Monitor: every pushed vector is compared mid-cycle, away from the clock edge.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            chk(mon_nm, "stall", 32'(X1_Stall),      32'(mon_e.stall));
            chk(mon_nm, "flush", 32'(X1_Flush),      32'(mon_e.flush));
            chk(mon_nm, "issue", 32'(X1_Issue),      32'(mon_e.issue));
            chk(mon_nm, "fwd1",  X1_ReadData1_Fwd,   mon_e.f1);
            chk(mon_nm, "fwd2",  X1_ReadData2_Fwd,   mon_e.f2);
            chk(mon_nm, "busy",  32'(X1_DivBusy),    32'(mon_e.busy));
            chk(mon_nm, "cnt",   32'(X1_StallCount), 32'(mon_e.cnt));
        end
    end

    task automatic push(input string nm, input logic st, input logic fl, input logic is,
                        input logic [31:0] f1, input logic [31:0] f2,
                        input logic bz, input logic [3:0] ct);
        exp_t e;
        e.stall = st; e.flush = fl; e.issue = is;
        e.f1 = f1; e.f2 = f2; e.busy = bz; e.cnt = ct;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic clr();
        reset = 1'b0; X1_Issued = 1'b0; X1_Rs = 5'd0; X1_Rt = 5'd0;
        X1_NeedRs = 1'b0; X1_NeedRt = 1'b0; X1_ReadData1 = RD1; X1_ReadData2 = RD2;
        X1_HiRead = 1'b0; X1_LoRead = 1'b0; X1_DivStart = 1'b0;
        X2_RegWrite = 1'b0; M1_RegWrite = 1'b0; W1_RegWrite = 1'b0;
        X2_Rd = 5'd0; M1_Rd = 5'd0; W1_Rd = 5'd0; X2_Ready = 1'b0; M1_Ready = 1'b0;
        X2_Result = 32'h0; M1_Result = 32'h0; W1_Result = 32'h0;
        M1_Stall = 1'b0; W1_Exception = 1'b0;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
        clr();
    endtask

    initial begin
        clr();
        reset = 1'b1;

        // Reset: stall suppressed, issue follows formula, divide not loaded.
        next(); reset = 1'b1; X1_Issued = 1'b1; M1_Stall = 1'b1; X1_DivStart = 1'b1;
        push("reset", 0, 0, 1, RD1, RD2, 0, 4'd0);
        next();
        push("post_reset", 0, 0, 0, RD1, RD2, 0, 4'd0);

        // Load-use: M1 not ready for two cycles.
        for (int k = 0; k < 2; k++) begin
            next(); X1_Issued = 1'b1; X1_Rs = 5'd7; X1_NeedRs = 1'b1;
            M1_RegWrite = 1'b1; M1_Rd = 5'd7; M1_Ready = 1'b0;
            push($sformatf("loaduse_wait%0d", k), 1, 0, 0, 32'h0, RD2, 0, 4'(k));
        end
        next(); X1_Issued = 1'b1; X1_Rs = 5'd7; X1_NeedRs = 1'b1;
        M1_RegWrite = 1'b1; M1_Rd = 5'd7; M1_Ready = 1'b1; M1_Result = 32'h55;
        push("loaduse_go", 0, 0, 1, 32'h55, RD2, 0, 4'd2);

        // X2 over M1 on Rs; W1 supplies Rt.
        next(); X1_Issued = 1'b1; X1_Rs = 5'd5; X1_NeedRs = 1'b1; X1_Rt = 5'd9; X1_NeedRt = 1'b1;
        X2_RegWrite = 1'b1; X2_Rd = 5'd5; X2_Ready = 1'b1; X2_Result = 32'hAAAA_0000;
        M1_RegWrite = 1'b1; M1_Rd = 5'd5; M1_Ready = 1'b1; M1_Result = 32'h1111;
        W1_RegWrite = 1'b1; W1_Rd = 5'd9; W1_Result = 32'h999;
        push("prio_x2", 0, 0, 1, 32'hAAAA_0000, 32'h999, 0, 4'd2);

        // M1 over W1 on both operands.
        next(); X1_Issued = 1'b1; X1_Rs = 5'd6; X1_Rt = 5'd6; X1_NeedRs = 1'b1;
        M1_RegWrite = 1'b1; M1_Rd = 5'd6; M1_Ready = 1'b1; M1_Result = 32'h66;
        W1_RegWrite = 1'b1; W1_Rd = 5'd6; W1_Result = 32'h77;
        push("prio_m1", 0, 0, 1, 32'h66, 32'h66, 0, 4'd2);

        // Unready X2 match stalls despite ready older M1 match; unneeded does not.
        for (int k = 0; k < 2; k++) begin
            next(); X1_Issued = 1'b1; X1_Rs = 5'd8; X1_NeedRs = (k == 0);
            X2_RegWrite = 1'b1; X2_Rd = 5'd8; X2_Ready = 1'b0; X2_Result = 32'hDEAD;
            M1_RegWrite = 1'b1; M1_Rd = 5'd8; M1_Ready = 1'b1; M1_Result = 32'hBEEF;
            if (k == 0) push("young_unready", 1, 0, 0, 32'hDEAD, RD2, 0, 4'd2);
            else        push("not_needed",    0, 0, 1, 32'hDEAD, RD2, 0, 4'd3);
        end

        // Rt hazard.
        next(); X1_Issued = 1'b1; X1_Rt = 5'd12; X1_NeedRt = 1'b1;
        X2_RegWrite = 1'b1; X2_Rd = 5'd12; X2_Ready = 1'b0; X2_Result = 32'hC;
        push("rt_hazard", 1, 0, 0, RD1, 32'hC, 0, 4'd3);

        // Register 0 never forwards nor stalls.
        next(); X1_Issued = 1'b1; X1_NeedRs = 1'b1; X1_NeedRt = 1'b1;
        X2_RegWrite = 1'b1; X2_Rd = 5'd0; X2_Ready = 1'b0; X2_Result = 32'hFFFF_FFFF;
        push("reg_zero", 0, 0, 1, RD1, RD2, 0, 4'd4);

        // Downstream stall with empty X1.
        next(); M1_Stall = 1'b1;
        push("m1stall_empty", 1, 0, 0, RD1, RD2, 0, 4'd4);

        // Exception beats data hazard and downstream stall.
        next(); X1_Issued = 1'b1; X1_Rs = 5'd7; X1_NeedRs = 1'b1;
        M1_RegWrite = 1'b1; M1_Rd = 5'd7; M1_Ready = 1'b0; M1_Result = 32'h3;
        M1_Stall = 1'b1; W1_Exception = 1'b1;
        push("flush_prio", 0, 1, 0, 32'h3, RD2, 0, 4'd5);

        // Divide interlock with a flush in the middle.
        next(); X1_Issued = 1'b1; X1_DivStart = 1'b1;
        push("div_issue", 0, 0, 1, RD1, RD2, 0, 4'd5);
        next(); X1_Issued = 1'b1; X1_HiRead = 1'b1;
        push("mfhi_t1", 1, 0, 0, RD1, RD2, 1, 4'd5);
        next(); X1_Issued = 1'b1; X1_LoRead = 1'b1;
        push("mflo_t2", 1, 0, 0, RD1, RD2, 1, 4'd6);
        next(); X1_Issued = 1'b1; X1_HiRead = 1'b1; W1_Exception = 1'b1;
        push("div_flush_t3", 0, 1, 0, RD1, RD2, 1, 4'd7);
        next(); X1_Issued = 1'b1; X1_DivStart = 1'b1;
        push("div_on_last", 1, 0, 0, RD1, RD2, 1, 4'd7);
        next(); X1_Issued = 1'b1; X1_HiRead = 1'b1;
        push("mfhi_t5", 0, 0, 1, RD1, RD2, 0, 4'd8);

        // Reset mid-divide.
        next(); X1_Issued = 1'b1; X1_DivStart = 1'b1;
        push("div_issue2", 0, 0, 1, RD1, RD2, 0, 4'd8);
        next(); reset = 1'b1; X1_Issued = 1'b1; X1_HiRead = 1'b1;
        push("reset_mid_div", 0, 0, 1, RD1, RD2, 1, 4'd8);
        next(); X1_Issued = 1'b1; X1_HiRead = 1'b1;
        push("after_reset_div", 0, 0, 1, RD1, RD2, 0, 4'd0);

        // Counter saturation at 15.
        for (int k = 0; k < 20; k++) begin
            next(); X1_Issued = 1'b1; M1_Stall = 1'b1;
            push($sformatf("sat%0d", k), 1, 0, 0, RD1, RD2, 0, 4'((k > 15) ? 15 : k));
        end
        next();
        push("sat_hold", 0, 0, 0, RD1, RD2, 0, 4'd15);

        next();
        repeat (3) @(posedge clock);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
